// File: rtl/buyruk_obek_getirici.sv
// Instruction-cache line-fill engine: fetches a 4-word block one word at a time from memory.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (missed word first, wrapping order).
module buyruk_obek_getirici #(
  parameter int unsigned BEKLEME_SINIRI = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         istek_i,
  input  logic [31:0]  adres_i,
  output logic         mesgul_o,
  output logic [127:0] buyruk_obegi_o,
  output logic         obek_geldi_o,
  output logic         hata_o,
  output logic [31:0]  ilk_buyruk_o,
  output logic         ilk_buyruk_gecerli_o,
  output logic         bellek_istek_o,
  output logic [31:0]  bellek_adres_o,
  input  logic         bellek_kabul_i,
  input  logic [31:0]  bellek_veri_i,
  input  logic         bellek_veri_gecerli_i
);

  typedef enum logic [1:0] {StBosta, StIstek, StVeri, StTamam} durum_e;

  localparam logic [7:0] BeklemeSon = 8'(BEKLEME_SINIRI - 1);

  durum_e       durum_q;
  logic [27:0]  satir_q;
  logic [1:0]   k_q;
  logic [1:0]   vurus_q;
  logic [7:0]   bekleme_q;
  logic [127:0] obek_q;
  logic         mesgul_q;
  logic         obek_geldi_q;
  logic         hata_q;
  logic         bellek_istek_q;
  logic [1:0]   ilk_k;
  logic         bekleme_doldu;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [31:0] ilk_buyruk_q;
  logic        ilk_gecerli_q;
  logic        unused_adres;

  assign ilk_k        = adres_i[3:2];
  assign unused_adres = ^adres_i[1:0];
`else
  logic unused_adres;

  assign ilk_k        = 2'd0;
  assign unused_adres = ^adres_i[3:0];
`endif

  assign bekleme_doldu = (bekleme_q == BeklemeSon);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q        <= StBosta;
      satir_q        <= '0;
      k_q            <= '0;
      vurus_q        <= '0;
      bekleme_q      <= '0;
      obek_q         <= '0;
      mesgul_q       <= 1'b0;
      obek_geldi_q   <= 1'b0;
      hata_q         <= 1'b0;
      bellek_istek_q <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      ilk_buyruk_q   <= '0;
      ilk_gecerli_q  <= 1'b0;
`endif
    end else begin
      obek_geldi_q  <= 1'b0;
      hata_q        <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      ilk_gecerli_q <= 1'b0;
`endif
      unique case (durum_q)
        StBosta: begin
          if (istek_i) begin
            satir_q        <= adres_i[31:4];
            k_q            <= ilk_k;
            vurus_q        <= '0;
            bekleme_q      <= '0;
            mesgul_q       <= 1'b1;
            bellek_istek_q <= 1'b1;
            durum_q        <= StIstek;
          end
        end
        StIstek: begin
          if (bellek_kabul_i) begin
            bellek_istek_q <= 1'b0;
            bekleme_q      <= '0;
            durum_q        <= StVeri;
          end else if (bekleme_doldu) begin
            bellek_istek_q <= 1'b0;
            mesgul_q       <= 1'b0;
            hata_q         <= 1'b1;
            durum_q        <= StBosta;
          end else begin
            bekleme_q <= bekleme_q + 8'd1;
          end
        end
        StVeri: begin
          if (bellek_veri_gecerli_i) begin
            obek_q[{k_q, 5'd0} +: 32] <= bellek_veri_i;
            k_q       <= k_q + 2'd1;
            vurus_q   <= vurus_q + 2'd1;
            bekleme_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            if (vurus_q == 2'd0) begin
              ilk_buyruk_q  <= bellek_veri_i;
              ilk_gecerli_q <= 1'b1;
            end
`endif
            if (vurus_q == 2'd3) begin
              obek_geldi_q <= 1'b1;
              durum_q      <= StTamam;
            end else begin
              bellek_istek_q <= 1'b1;
              durum_q        <= StIstek;
            end
          end else if (bekleme_doldu) begin
            mesgul_q <= 1'b0;
            hata_q   <= 1'b1;
            durum_q  <= StBosta;
          end else begin
            bekleme_q <= bekleme_q + 8'd1;
          end
        end
        StTamam: begin
          // Completion cycle; a new request is only looked at once back in StBosta.
          mesgul_q <= 1'b0;
          durum_q  <= StBosta;
        end
        default: durum_q <= StBosta;
      endcase
    end
  end

  assign mesgul_o       = mesgul_q;
  assign buyruk_obegi_o = obek_q;
  assign obek_geldi_o   = obek_geldi_q;
  assign hata_o         = hata_q;
  assign bellek_istek_o = bellek_istek_q;
  assign bellek_adres_o = {satir_q, k_q, 2'b00};

`ifdef CRITICAL_WORD_FIRST_EN
  assign ilk_buyruk_o         = ilk_buyruk_q;
  assign ilk_buyruk_gecerli_o = ilk_gecerli_q;
`else
  assign ilk_buyruk_o         = '0;
  assign ilk_buyruk_gecerli_o = 1'b0;
`endif

endmodule

// File: tb/tb_buyruk_obek_getirici.sv
// Scoreboard bench for buyruk_obek_getirici: directed fills against a delay-configurable memory.
module tb_buyruk_obek_getirici;

  localparam int unsigned Sinir = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         istek_i;
  logic [31:0]  adres_i;
  logic         mesgul_o;
  logic [127:0] buyruk_obegi_o;
  logic         obek_geldi_o;
  logic         hata_o;
  logic [31:0]  ilk_buyruk_o;
  logic         ilk_buyruk_gecerli_o;
  logic         bellek_istek_o;
  logic [31:0]  bellek_adres_o;
  logic         bellek_kabul_i;
  logic [31:0]  bellek_veri_i;
  logic         bellek_veri_gecerli_i;

  buyruk_obek_getirici #(.BEKLEME_SINIRI(Sinir)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .istek_i              (istek_i),
    .adres_i              (adres_i),
    .mesgul_o             (mesgul_o),
    .buyruk_obegi_o       (buyruk_obegi_o),
    .obek_geldi_o         (obek_geldi_o),
    .hata_o               (hata_o),
    .ilk_buyruk_o         (ilk_buyruk_o),
    .ilk_buyruk_gecerli_o (ilk_buyruk_gecerli_o),
    .bellek_istek_o       (bellek_istek_o),
    .bellek_adres_o       (bellek_adres_o),
    .bellek_kabul_i       (bellek_kabul_i),
    .bellek_veri_i        (bellek_veri_i),
    .bellek_veri_gecerli_i(bellek_veri_gecerli_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] blk;
    int           t;
  } blk_t;

  typedef struct {
    logic [31:0] veri;
    int          t;
  } ilk_t;

  blk_t        blk_q[$];
  ilk_t        ilk_q[$];
  int          hata_q[$];
  logic [31:0] adr_q[$];

  int checks = 0;
  int errors = 0;

  // Memory model knobs
  int          kabul_gec = 0;
  int          veri_gec  = 0;
  bit          dusur     = 1'b0;
  logic [31:0] taban     = 32'hA0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] bas_k(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return a[3:2];
`else
    return 2'd0;
`endif
  endfunction

  // t0 is the cycle index right after the edge that samples istek_i; t0 < 0 skips timing.
  task automatic beklenen(input logic [31:0] a, input logic [31:0] b, input int t0,
                          input int n_kabul, input bit tamam, input bit ilk);
    logic [1:0] k;
    blk_t       e;
    ilk_t       f;
    k = bas_k(a);
    for (int i = 0; i < n_kabul; i++) begin
      adr_q.push_back({a[31:4], 2'(k + 2'(i)), 2'b00});
    end
    if (tamam) begin
      e.blk = {b + 32'd3, b + 32'd2, b + 32'd1, b};
      e.t   = (t0 < 0) ? -1 : t0 + 8;
      blk_q.push_back(e);
    end
`ifdef CRITICAL_WORD_FIRST_EN
    if (ilk) begin
      f.veri = b + 32'(k);
      f.t    = (t0 < 0) ? -1 : t0 + 2;
      ilk_q.push_back(f);
    end
`else
    f.veri = '0;
    f.t    = 0;
    if (ilk && f.t != 0) ilk_q.push_back(f);
`endif
  endtask

  task automatic gonder(input logic [31:0] a, input bit tut, output int t0);
    @(negedge clk_i);
    istek_i = 1'b1;
    adres_i = a;
    @(posedge clk_i);
    #1;
    t0 = cyc;
    if (!tut) istek_i = 1'b0;
  endtask

  task automatic bitir_bekle(input int butce);
    int n;
    n = 0;
    while ((adr_q.size() + blk_q.size() + hata_q.size() + ilk_q.size()) != 0 && n < butce) begin
      @(negedge clk_i);
      n++;
    end
    check("scoreboard_drained", 128'(adr_q.size() + blk_q.size() + hata_q.size() + ilk_q.size()),
          128'd0);
    repeat (2) @(negedge clk_i);
  endtask

  // Memory responder; also checks request addresses and their stability while waiting.
  initial begin
    int          st;
    int          cnt;
    logic [31:0] a_tut;
    st = 0;
    cnt = 0;
    a_tut = '0;
    bellek_kabul_i = 1'b0;
    bellek_veri_gecerli_i = 1'b0;
    bellek_veri_i = '0;
    forever begin
      @(negedge clk_i);
      bellek_kabul_i = 1'b0;
      bellek_veri_gecerli_i = 1'b0;
      if (rst_i || !mesgul_o) begin
        st = 0;
        cnt = 0;
      end else if (st == 0) begin
        if (bellek_istek_o) begin
          if (cnt == 0) a_tut = bellek_adres_o;
          else check("adres_stable", 128'(bellek_adres_o), 128'(a_tut));
          if (cnt >= kabul_gec) begin
            bellek_kabul_i = 1'b1;
            if (adr_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL adres_unexpected: got %h expected none", bellek_adres_o);
            end else begin
              check("bellek_adres", 128'(bellek_adres_o), 128'(adr_q.pop_front()));
            end
            st = 1;
            cnt = 0;
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt >= veri_gec && !(dusur && a_tut[3:2] == 2'd1)) begin
          bellek_veri_gecerli_i = 1'b1;
          bellek_veri_i = taban + 32'(a_tut[3:2]);
          st = 0;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Output monitor
  initial begin
    blk_t e;
    ilk_t f;
    int   h;
    forever begin
      @(negedge clk_i);
      if (obek_geldi_o) begin
        if (blk_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL obek_unexpected: got pulse at %0d expected none", cyc);
        end else begin
          e = blk_q.pop_front();
          check("obek", buyruk_obegi_o, e.blk);
          if (e.t >= 0) check("obek_cycle", 128'(cyc), 128'(e.t));
`ifndef CRITICAL_WORD_FIRST_EN
          check("ilk_tied", 128'(ilk_buyruk_o), 128'd0);
`endif
        end
      end
      if (hata_o) begin
        if (hata_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hata_unexpected: got pulse at %0d expected none", cyc);
        end else begin
          h = hata_q.pop_front();
          check("hata_cycle", 128'(cyc), 128'(h));
          check("hata_mesgul", 128'(mesgul_o), 128'd0);
        end
      end
      if (ilk_buyruk_gecerli_o) begin
        if (ilk_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ilk_unexpected: got pulse at %0d expected none", cyc);
        end else begin
          f = ilk_q.pop_front();
          check("ilk_veri", 128'(ilk_buyruk_o), 128'(f.veri));
          if (f.t >= 0) check("ilk_cycle", 128'(cyc), 128'(f.t));
        end
      end
    end
  end

  initial begin
    int t0;
    rst_i   = 1'b1;
    istek_i = 1'b0;
    adres_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mesgul", 128'(mesgul_o), 128'd0);
    check("rst_obek", buyruk_obegi_o, 128'd0);
    check("rst_istek", 128'(bellek_istek_o), 128'd0);
    check("rst_pulses", 128'({obek_geldi_o, hata_o, ilk_buyruk_gecerli_o}), 128'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Zero-wait fills at two offsets
    gonder(32'h0000_1234, 1'b0, t0);
    beklenen(32'h0000_1234, 32'hA0, t0, 4, 1'b1, 1'b1);
    bitir_bekle(40);
    gonder(32'h0000_1238, 1'b0, t0);
    beklenen(32'h0000_1238, 32'hA0, t0, 4, 1'b1, 1'b1);
    bitir_bekle(40);

    // Slow memory: 3-cycle accept, 5-cycle data
    kabul_gec = 3;
    veri_gec  = 5;
    taban     = 32'h5550;
    gonder(32'h0000_4A74, 1'b0, t0);
    beklenen(32'h0000_4A74, 32'h5550, -1, 4, 1'b1, 1'b1);
    bitir_bekle(200);

    // Word 1 never returns: abort after Sinir cycles in VERI
    kabul_gec = 0;
    veri_gec  = 0;
    dusur     = 1'b1;
    taban     = 32'hA0;
    gonder(32'h0000_2000, 1'b0, t0);
    beklenen(32'h0000_2000, 32'hA0, t0, 2, 1'b0, 1'b1);
    hata_q.push_back(t0 + 11);
    bitir_bekle(60);
    check("hata_idle", 128'({mesgul_o, bellek_istek_o}), 128'd0);
    dusur = 1'b0;

    // istek_i held with a changed address: second fill starts from StBosta after TAMAM
    taban = 32'h0C00;
    gonder(32'h0000_6004, 1'b1, t0);
    adres_i = 32'h0000_7008;
    beklenen(32'h0000_6004, 32'h0C00, t0, 4, 1'b1, 1'b1);
    beklenen(32'h0000_7008, 32'h0C00, t0 + 10, 4, 1'b1, 1'b1);
    repeat (10) @(posedge clk_i);
    #1;
    istek_i = 1'b0;
    bitir_bekle(60);

    // Reset after two beats, then a clean fill
    taban = 32'hA0;
    gonder(32'h0000_3000, 1'b0, t0);
    beklenen(32'h0000_3000, 32'hA0, t0, 2, 1'b0, 1'b1);
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("midrst_mesgul", 128'(mesgul_o), 128'd0);
    check("midrst_obek", buyruk_obegi_o, 128'd0);
    check("midrst_istek", 128'({bellek_istek_o, bellek_adres_o}), 128'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bitir_bekle(10);
    gonder(32'h0000_3004, 1'b0, t0);
    beklenen(32'h0000_3004, 32'hA0, t0, 4, 1'b1, 1'b1);
    bitir_bekle(40);

    repeat (5) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
